// File: rtl/ps2_mouse_rx.sv
// ps2_mouse_rx
//
// Receive-only PS/2 mouse front end. Filters the raw PS/2 clock, samples the
// data line on each filtered falling edge, deframes 11-bit characters
// (start, 8 data LSB first, parity, stop), assembles 3-byte standard mouse
// packets and publishes each complete packet as one 25-bit word. Bit 24 of
// that word toggles once per accepted packet so a slower consumer can detect
// new data. The PS/2 lines are never driven.
//
// Parameters:
//   FILT_LEN  consecutive CLK samples a new PS/2 clock level must persist
//             before the filtered clock follows it (2..255)
//   TIMEOUT   CLK cycles without a filtered falling edge before an
//             in-progress frame or packet is abandoned (17-bit counter)
//
// Ports:
//   CLK       system clock, at least 20x the PS/2 clock rate
//   RESET     asynchronous, active-high reset
//   PS2_CLK   raw PS/2 clock line (asynchronous)
//   PS2_DATA  raw PS/2 data line (asynchronous)
//   MOUSE     [7:0] status, [15:8] X, [23:16] Y, [24] per-packet toggle
//   PKT_ERR   one-cycle pulse whenever a byte or packet is discarded
//
// Build option:
//   PS2_PARITY_CHECK_EN  when defined, the parity bit must make {data,parity}
//                        odd; a mismatch discards the byte. When undefined,
//                        the parity bit is clocked through and ignored.

module ps2_mouse_rx #(
  parameter int unsigned FILT_LEN = 8,
  parameter int unsigned TIMEOUT  = 100000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PS2_CLK,
  input  logic        PS2_DATA,
  output logic [24:0] MOUSE,
  output logic        PKT_ERR
);

  localparam logic [7:0]  FILT_LAST = 8'(FILT_LEN - 1);
  localparam logic [16:0] TO_LAST   = 17'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers; reset to the idle (high) line level.
  // ---------------------------------------------------------------------------
  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       ps2_clk_s;
  logic       ps2_dat_s;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DATA};
    end
  end

  assign ps2_clk_s = clk_sync[1];
  assign ps2_dat_s = dat_sync[1];

  // ---------------------------------------------------------------------------
  // Glitch filter. The counter tracks how many consecutive samples have
  // disagreed with the filtered level; any agreeing sample restarts it.
  // fe is asserted in the cycle whose closing edge flips the filtered clock
  // from 1 to 0, so the frame logic consumes the data sample on that edge.
  // ---------------------------------------------------------------------------
  logic       filt_clk;
  logic [7:0] filt_cnt;
  logic       fe;

  assign fe = filt_clk && !ps2_clk_s && (filt_cnt == FILT_LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (ps2_clk_s == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_LAST) begin
      filt_clk <= ps2_clk_s;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame / packet state
  // ---------------------------------------------------------------------------
  frame_state_t state_q, state_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]   shreg_q, shreg_d;
  logic [1:0]   idx_q, idx_d;
  logic [7:0]   byte0_q, byte0_d;
  logic [7:0]   byte1_q, byte1_d;
  logic [24:0]  mouse_q, mouse_d;
  logic         pkt_err_q, pkt_err_d;
  logic [16:0]  to_cnt_q, to_cnt_d;
`ifdef PS2_PARITY_CHECK_EN
  logic         par_q, par_d;
`endif

  logic         parity_ok;
  logic         byte_done;
  logic         byte_ok;
  logic         active;

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{shreg_q, par_q};
`else
  assign parity_ok = 1'b1;
`endif

  assign active = (state_q != IDLE) || (idx_q != 2'd0);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    byte0_d   = byte0_q;
    byte1_d   = byte1_q;
    mouse_d   = mouse_q;
    pkt_err_d = 1'b0;
    to_cnt_d  = to_cnt_q;
`ifdef PS2_PARITY_CHECK_EN
    par_d     = par_q;
`endif
    byte_done = 1'b0;
    byte_ok   = 1'b0;

    // A falling edge always clears the timeout counter, so it takes priority
    // over a terminal count landing in the same cycle.
    if (fe) begin
      to_cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (!ps2_dat_s) begin
            state_d   = DATA;
            shreg_d   = '0;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shreg_d   = {ps2_dat_s, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_d   = ps2_dat_s;
`endif
          state_d = STOP;
        end
        STOP: begin
          state_d   = IDLE;
          byte_done = 1'b1;
          byte_ok   = ps2_dat_s && parity_ok;
        end
        default: state_d = IDLE;
      endcase
    end else if (active) begin
      if (to_cnt_q == TO_LAST) begin
        to_cnt_d  = '0;
        state_d   = IDLE;
        idx_d     = 2'd0;
        pkt_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 17'd1;
      end
    end

    // Packet assembly. Dropping staged bytes only needs the index reset; the
    // staging registers are simply overwritten by the next packet.
    if (byte_done) begin
      if (!byte_ok || ((idx_q == 2'd0) && !shreg_q[3])) begin
        pkt_err_d = 1'b1;
        idx_d     = 2'd0;
      end else begin
        case (idx_q)
          2'd0: begin
            byte0_d = shreg_q;
            idx_d   = 2'd1;
          end
          2'd1: begin
            byte1_d = shreg_q;
            idx_d   = 2'd2;
          end
          default: begin
            mouse_d = {~mouse_q[24], shreg_q, byte1_q, byte0_q};
            idx_d   = 2'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      idx_q     <= '0;
      byte0_q   <= '0;
      byte1_q   <= '0;
      mouse_q   <= '0;
      pkt_err_q <= 1'b0;
      to_cnt_q  <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      byte0_q   <= byte0_d;
      byte1_q   <= byte1_d;
      mouse_q   <= mouse_d;
      pkt_err_q <= pkt_err_d;
      to_cnt_q  <= to_cnt_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q     <= par_d;
`endif
    end
  end

  assign MOUSE   = mouse_q;
  assign PKT_ERR = pkt_err_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Testbench for ps2_mouse_rx: drives PS/2 frames, models packet assembly
// at byte level, and checks every MOUSE update and PKT_ERR pulse in order.
module tb_ps2_mouse_rx;

  localparam int unsigned FILT = 8;
  localparam int unsigned TOUT = 600;
  localparam int unsigned HALF = 20;
  localparam int unsigned GAP  = 30;

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        PS2_CLK = 1'b1;
  logic        PS2_DATA = 1'b1;
  logic [24:0] MOUSE;
  logic        PKT_ERR;

  ps2_mouse_rx #(.FILT_LEN(FILT), .TIMEOUT(TOUT)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .PS2_CLK(PS2_CLK),
    .PS2_DATA(PS2_DATA),
    .MOUSE(MOUSE),
    .PKT_ERR(PKT_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        is_err;
    logic [24:0] val;
  } ev_t;

  ev_t         exp_q[$];
  logic [7:0]  m_stage[$];
  logic [24:0] m_mouse = '0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [24:0] act, input logic [24:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic flag_fail(input string name, input string what);
    total++;
    bad++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic void push_err();
    ev_t e;
    e.is_err = 1'b1;
    e.val    = '0;
    exp_q.push_back(e);
    m_stage.delete();
  endfunction

  // Byte-level reference: a byte is rejected for a bad stop bit, a bad
  // parity bit (when checking is on), or a missing sync bit as first byte.
  function automatic void model_byte(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    ev_t e;
    if (stop_bad || (par_bad && PAR_EN) || (m_stage.size() == 0 && !b[3])) begin
      push_err();
    end else begin
      m_stage.push_back(b);
      if (m_stage.size() == 3) begin
        m_mouse  = {~m_mouse[24], m_stage[2], m_stage[1], m_stage[0]};
        e.is_err = 1'b0;
        e.val    = m_mouse;
        exp_q.push_back(e);
        m_stage.delete();
      end
    end
  endfunction

  task automatic ps2_bit(input logic b, input bit glitch);
    @(negedge CLK);
    PS2_DATA = b;
    if (glitch) begin
      repeat (3) @(negedge CLK);
      PS2_CLK = 1'b0;
      repeat (FILT - 1) @(negedge CLK);
      PS2_CLK = 1'b1;
      repeat (HALF - 3 - (FILT - 1)) @(negedge CLK);
    end else begin
      repeat (HALF) @(negedge CLK);
    end
    PS2_CLK = 1'b0;
    repeat (HALF) @(negedge CLK);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit par_bad, input bit stop_bad, input bit glitch);
    logic par;
    model_byte(b, par_bad, stop_bad);
    par = (~^b) ^ par_bad;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch && (i == 4));
    ps2_bit(par, 1'b0);
    ps2_bit(!stop_bad, 1'b0);
    @(negedge CLK);
    PS2_DATA = 1'b1;
    repeat (GAP) @(negedge CLK);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0, 1'b0, 1'b0);
    send_byte(b1, 1'b0, 1'b0, 1'b0);
    send_byte(b2, 1'b0, 1'b0, 1'b0);
  endtask

  // Start bit plus nbits data bits, then the line goes quiet.
  task automatic send_partial(input int unsigned nbits, input bit expect_timeout);
    if (expect_timeout) push_err();
    ps2_bit(1'b0, 1'b0);
    for (int unsigned i = 0; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0);
    @(negedge CLK);
    PS2_DATA = 1'b1;
    if (expect_timeout) repeat (TOUT + 100) @(negedge CLK);
  endtask

  task automatic silence();
    if (m_stage.size() != 0) push_err();
    repeat (TOUT + 100) @(negedge CLK);
  endtask

  // Monitor: every observed MOUSE change or PKT_ERR pulse must match the
  // head of the expectation queue.
  task automatic monitor();
    logic [24:0] prev;
    ev_t e;
    prev = '0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        prev = MOUSE;
      end else begin
        if (MOUSE !== prev) begin
          if (exp_q.size() == 0) begin
            flag_fail("mouse_unexpected", $sformatf("MOUSE became %h with nothing expected", MOUSE));
          end else begin
            e = exp_q.pop_front();
            if (e.is_err) flag_fail("mouse_vs_err", $sformatf("MOUSE became %h, required a PKT_ERR pulse", MOUSE));
            else check("mouse_word", MOUSE, e.val);
          end
        end
        if (PKT_ERR !== 1'b0) begin
          if (PKT_ERR !== 1'b1) begin
            flag_fail("pkt_err_x", "PKT_ERR is X/Z, required 0 or 1");
          end else if (exp_q.size() == 0) begin
            flag_fail("err_unexpected", "PKT_ERR pulse with nothing expected");
          end else begin
            e = exp_q.pop_front();
            if (!e.is_err) flag_fail("err_vs_mouse", $sformatf("PKT_ERR pulse, required MOUSE=%h", e.val));
            else check("err_pulse", {24'd0, PKT_ERR}, 25'd1);
          end
        end
        prev = MOUSE;
      end
    end
  endtask

  initial begin
    repeat (95000) @(posedge CLK);
    $display("FAIL watchdog: cycle budget expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int unsigned r;
    fork
      monitor();
    join_none

    // Reset state
    repeat (5) @(negedge CLK);
    check("reset_mouse", MOUSE, 25'd0);
    check("reset_err", {24'd0, PKT_ERR}, 25'd0);
    RESET = 1'b0;
    repeat (5) @(negedge CLK);
    check("post_reset_mouse", MOUSE, 25'd0);

    // Valid packet
    send_pkt(8'h29, 8'h05, 8'hFD);
    check("valid_pkt", MOUSE, 25'h1FD0529);

    // Parity error on byte 1, then a good packet
    send_byte(8'h29, 1'b0, 1'b0, 1'b0);
    send_byte(8'h05, 1'b1, 1'b0, 1'b0);
    send_byte(8'hFD, 1'b0, 1'b0, 1'b0);
    send_pkt(8'h08, 8'h10, 8'h20);
    check("after_parity", MOUSE, m_mouse);

    // Sync loss then realignment
    send_byte(8'h21, 1'b0, 1'b0, 1'b0);
    send_pkt(8'h29, 8'h05, 8'hFD);
    check("after_sync", MOUSE, m_mouse);

    // Stop-bit error on byte 2
    send_byte(8'h18, 1'b0, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b1, 1'b0);

    // Timeout mid-frame after byte 0, then a full packet
    send_byte(8'h29, 1'b0, 1'b0, 1'b0);
    send_partial(4, 1'b1);
    send_pkt(8'h38, 8'h7F, 8'h80);
    check("after_timeout", MOUSE, m_mouse);

    // Timeout with only a staged byte pending
    send_byte(8'hC8, 1'b0, 1'b0, 1'b0);
    silence();

    // Clock glitches shorter than the filter
    send_byte(8'h2A, 1'b0, 1'b0, 1'b1);
    send_byte(8'h5B, 1'b0, 1'b0, 1'b1);
    send_byte(8'hA6, 1'b0, 1'b0, 1'b1);
    check("after_glitch", MOUSE, m_mouse);

    // Randomized byte stream with occasional faults and silences
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        silence();
      end else if (r < 8) begin
        send_partial($urandom_range(0, 7), 1'b1);
      end else begin
        b = 8'($urandom);
        if (m_stage.size() == 0 && r < 75) b[3] = 1'b1;
        send_byte(b, ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0), 1'b0);
      end
    end
    repeat (50) @(negedge CLK);
    check("queue_drained_mid", 25'(exp_q.size()), 25'd0);

    // Reset mid-byte 1
    send_byte(8'h29, 1'b0, 1'b0, 1'b0);
    send_partial(3, 1'b0);
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    check("midreset_mouse", MOUSE, 25'd0);
    check("midreset_err", {24'd0, PKT_ERR}, 25'd0);
    m_mouse = '0;
    m_stage.delete();
    PS2_DATA = 1'b1;
    PS2_CLK  = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    repeat (10) @(negedge CLK);
    send_pkt(8'h09, 8'h01, 8'h02);
    check("post_midreset", MOUSE, 25'h1020109);

    // Drain with a bounded wait
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge CLK);
    check("queue_drained", 25'(exp_q.size()), 25'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
